// File: rtl/lfsr_rr_scheduler.sv
// -----------------------------------------------------------------------------
// lfsr_rr_scheduler
//
// Shares one 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1) among NREQ requesters.
// A round-robin arbiter picks the next requester. The winner then receives a
// burst of BURST consecutive LFSR words. A reseed requested during a burst is
// held pending and applied in a one-cycle SEED state after the burst ends.
//
// Parameters
//   NREQ   number of requesters (2..8)
//   BURST  words delivered per grant (1..16)
//   SEED   LFSR value after reset and lockup-guard replacement (nonzero)
//
// Ports
//   clk          clock, rising edge
//   rst          synchronous reset, active low
//   req_i        per-requester request level
//   gnt_o        one-hot grant, held for the whole burst
//   rnd_valid_o  rnd_data_o is a valid burst word
//   rnd_data_o   current LFSR state
//   rnd_id_o     index of the granted requester, 0 when idle
//   seed_load_i  single-cycle reseed strobe
//   seed_data_i  reseed value, sampled with seed_load_i
//   rnd_ready_i  consumer ready (only with LFSR_SCHED_STALL_EN)
//   busy_o       high while in BURST or SEED
//
// Build option
//   LFSR_SCHED_STALL_EN  adds rnd_ready_i. A beat is accepted only on
//                        rnd_valid_o && rnd_ready_i. Without it, every
//                        BURST cycle is an accepted beat.
// -----------------------------------------------------------------------------
module lfsr_rr_scheduler #(
    parameter int          NREQ  = 4,
    parameter int          BURST = 4,
    parameter logic [7:0]  SEED  = 8'h01
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req_i,
    output logic [NREQ-1:0] gnt_o,
    output logic            rnd_valid_o,
    output logic [7:0]      rnd_data_o,
    output logic [2:0]      rnd_id_o,
    input  logic            seed_load_i,
    input  logic [7:0]      seed_data_i,
`ifdef LFSR_SCHED_STALL_EN
    input  logic            rnd_ready_i,
`endif
    output logic            busy_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BURST = 2'd1,
        S_SEED  = 2'd2
    } state_t;

    // One Fibonacci step: the feedback taps are s[7], s[5], s[4] and s[3].
    function automatic logic [7:0] lfsr_step(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

    state_t          state_q, state_d;
    logic [7:0]      lfsr_q, lfsr_d;
    logic [2:0]      ptr_q, ptr_d;
    logic [4:0]      cnt_q, cnt_d;
    logic            pend_v_q, pend_v_d;
    logic [7:0]      pend_data_q, pend_data_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [2:0]      id_q, id_d;
    logic            valid_q, valid_d;
    logic            busy_q, busy_d;

    logic [7:0]      req_ext_s;
    logic [7:0]      onehot_s;
    logic [3:0]      idx_s;
    logic [2:0]      win_s;
    logic            found_s;
    logic            accept_s;

    assign req_ext_s = 8'(req_i);
    assign onehot_s  = 8'd1 << win_s;

`ifdef LFSR_SCHED_STALL_EN
    assign accept_s = valid_q & rnd_ready_i;
`else
    assign accept_s = valid_q;
`endif

    // Round-robin search: the first set request at or after ptr_q, wrapping modulo NREQ.
    always_comb begin
        win_s   = 3'd0;
        found_s = 1'b0;
        idx_s   = 4'd0;
        for (int k = 0; k < NREQ; k++) begin
            idx_s = {1'b0, ptr_q} + 4'(k);
            if (idx_s >= 4'(NREQ)) begin
                idx_s = idx_s - 4'(NREQ);
            end else begin
                idx_s = idx_s;
            end
            if (!found_s && req_ext_s[idx_s[2:0]]) begin
                win_s   = idx_s[2:0];
                found_s = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

    // Next-state and next-output logic. The outputs are computed one cycle ahead so they can be registered.
    always_comb begin
        state_d     = state_q;
        lfsr_d      = lfsr_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        pend_v_d    = pend_v_q;
        pend_data_d = pend_data_q;
        gnt_d       = gnt_q;
        id_d        = id_q;
        valid_d     = valid_q;
        busy_d      = busy_q;
        case (state_q)
            S_IDLE: begin
                if (pend_v_q || seed_load_i) begin
                    // A fresh strobe overrides an older pending value.
                    if (seed_load_i) begin
                        pend_v_d    = 1'b1;
                        pend_data_d = seed_data_i;
                    end else begin
                        pend_v_d    = pend_v_q;
                    end
                    state_d = S_SEED;
                    gnt_d   = '0;
                    id_d    = 3'd0;
                    valid_d = 1'b0;
                    busy_d  = 1'b1;
                end else if (found_s) begin
                    state_d = S_BURST;
                    gnt_d   = onehot_s[NREQ-1:0];
                    id_d    = win_s;
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                    cnt_d   = 5'd0;
                    ptr_d   = (win_s == 3'(NREQ - 1)) ? 3'd0 : win_s + 3'd1;
                end else begin
                    gnt_d   = '0;
                    id_d    = 3'd0;
                    valid_d = 1'b0;
                    busy_d  = 1'b0;
                end
            end
            S_BURST: begin
                // A reseed is deferred until the burst completes. A later strobe overwrites an earlier one.
                if (seed_load_i) begin
                    pend_v_d    = 1'b1;
                    pend_data_d = seed_data_i;
                end else begin
                    pend_v_d    = pend_v_q;
                end
                if (accept_s) begin
                    lfsr_d = lfsr_step(lfsr_q);
                    if (cnt_q == 5'(BURST - 1)) begin
                        state_d = S_IDLE;
                        cnt_d   = 5'd0;
                        gnt_d   = '0;
                        id_d    = 3'd0;
                        valid_d = 1'b0;
                        busy_d  = 1'b0;
                    end else begin
                        cnt_d   = cnt_q + 5'd1;
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end
            S_SEED: begin
                // Lockup guard: an all-zero seed would freeze the LFSR.
                lfsr_d = (pend_data_q == 8'h00) ? SEED : pend_data_q;
                if (seed_load_i) begin
                    pend_v_d    = 1'b1;
                    pend_data_d = seed_data_i;
                end else begin
                    pend_v_d    = 1'b0;
                end
                state_d = S_IDLE;
                gnt_d   = '0;
                id_d    = 3'd0;
                valid_d = 1'b0;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
                gnt_d   = '0;
                id_d    = 3'd0;
                valid_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers, with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            lfsr_q      <= SEED;
            ptr_q       <= 3'd0;
            cnt_q       <= 5'd0;
            pend_v_q    <= 1'b0;
            pend_data_q <= 8'h00;
            gnt_q       <= '0;
            id_q        <= 3'd0;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            lfsr_q      <= lfsr_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            pend_v_q    <= pend_v_d;
            pend_data_q <= pend_data_d;
            gnt_q       <= gnt_d;
            id_q        <= id_d;
            valid_q     <= valid_d;
            busy_q      <= busy_d;
        end
    end

    assign gnt_o       = gnt_q;
    assign rnd_valid_o = valid_q;
    assign rnd_data_o  = lfsr_q;
    assign rnd_id_o    = id_q;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_lfsr_rr_scheduler.sv
// -----------------------------------------------------------------------------
// tb_lfsr_rr_scheduler
//
// Directed bench for lfsr_rr_scheduler. When a request is driven, the bench
// uses its own LFSR and round-robin model to push the expected beats
// (id, word) into a queue. Each beat is popped and compared when the DUT
// shows rnd_valid.
// -----------------------------------------------------------------------------
module tb_lfsr_rr_scheduler;

    localparam int         NREQ  = 4;
    localparam int         BURST = 4;
    localparam logic [7:0] SEED  = 8'h01;

    typedef struct packed {
        logic [2:0] id;
        logic [7:0] data;
    } beat_t;

    logic            clk = 1'b0;
    logic            rst;
    logic [NREQ-1:0] req;
    logic [NREQ-1:0] gnt;
    logic            rnd_valid;
    logic [7:0]      rnd_data;
    logic [2:0]      rnd_id;
    logic            seed_load;
    logic [7:0]      seed_data;
    logic            busy;
`ifdef LFSR_SCHED_STALL_EN
    logic            rdy;
    int              stall_beat = -1;
`endif

    int    checks   = 0;
    int    failures = 0;
    beat_t exp_q[$];
    logic [7:0] m_lfsr;
    logic [2:0] m_ptr;

    lfsr_rr_scheduler #(.NREQ(NREQ), .BURST(BURST), .SEED(SEED)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_i       (req),
        .gnt_o       (gnt),
        .rnd_valid_o (rnd_valid),
        .rnd_data_o  (rnd_data),
        .rnd_id_o    (rnd_id),
        .seed_load_i (seed_load),
        .seed_data_i (seed_data),
`ifdef LFSR_SCHED_STALL_EN
        .rnd_ready_i (rdy),
`endif
        .busy_o      (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] m_step(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Model the arbitration decision for a held request vector and queue the burst it should produce.
    task automatic expect_burst(input logic [NREQ-1:0] r);
        logic [2:0] win;
        bit         found;
        beat_t      e;
        win   = 3'd0;
        found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            int idx;
            idx = (int'(m_ptr) + k) % NREQ;
            if (!found && r[idx]) begin
                win   = 3'(idx);
                found = 1'b1;
            end
        end
        m_ptr = (win == 3'(NREQ - 1)) ? 3'd0 : win + 3'd1;
        for (int b = 0; b < BURST; b++) begin
            e.id   = win;
            e.data = m_lfsr;
            exp_q.push_back(e);
            m_lfsr = m_step(m_lfsr);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_gnt"},   32'(gnt),       32'd0);
        chk({tag, "_valid"}, 32'(rnd_valid), 32'd0);
        chk({tag, "_busy"},  32'(busy),      32'd0);
        chk({tag, "_id"},    32'(rnd_id),    32'd0);
        chk({tag, "_data"},  32'(rnd_data),  32'(SEED));
    endtask

    // Wait for the grant, then compare each beat against the scoreboard.
    // Optional actions: a seed strobe on beat seed_beat, a reset on beat rst_beat.
    task automatic check_burst(input int seed_beat, input logic [7:0] seed_val, input int rst_beat);
        int    n;
        beat_t e;
        n = 0;
        while (rnd_valid !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
        chk("grant_wait", 32'(rnd_valid), 32'd1);
        if (rnd_valid !== 1'b1) begin
            exp_q.delete();
            return;
        end
        for (int b = 0; b < BURST; b++) begin
            if (exp_q.size() == 0) begin
                chk("queue_empty", 32'd0, 32'd1);
                return;
            end
            e = exp_q[0];
            chk("beat_valid", 32'(rnd_valid), 32'd1);
            chk("beat_busy",  32'(busy),      32'd1);
            chk("beat_id",    32'(rnd_id),    32'(e.id));
            chk("beat_gnt",   32'(gnt),       32'd1 << e.id);
            chk("beat_data",  32'(rnd_data),  32'(e.data));
            if (b == rst_beat) begin
                rst = 1'b0;
                tick();
                check_reset_outputs("midburst_rst");
                rst    = 1'b1;
                exp_q.delete();
                m_lfsr = SEED;
                m_ptr  = 3'd0;
                return;
            end
            if (b == seed_beat) begin
                seed_load = 1'b1;
                seed_data = seed_val;
            end
`ifdef LFSR_SCHED_STALL_EN
            if (b == stall_beat) begin
                rdy = 1'b0;
                repeat (3) begin
                    tick();
                    chk("stall_data",  32'(rnd_data),  32'(e.data));
                    chk("stall_gnt",   32'(gnt),       32'd1 << e.id);
                    chk("stall_valid", 32'(rnd_valid), 32'd1);
                end
                rdy = 1'b1;
            end
`endif
            void'(exp_q.pop_front());
            tick();
            seed_load = 1'b0;
        end
        chk("post_valid", 32'(rnd_valid), 32'd0);
        chk("post_gnt",   32'(gnt),       32'd0);
        chk("post_busy",  32'(busy),      32'd0);
        chk("post_id",    32'(rnd_id),    32'd0);
    endtask

    // Hard stop in case the sequence below stalls.
    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b0;
        req       = '0;
        seed_load = 1'b0;
        seed_data = 8'h00;
`ifdef LFSR_SCHED_STALL_EN
        rdy       = 1'b1;
`endif
        m_lfsr    = SEED;
        m_ptr     = 3'd0;

        // Reset state.
        tick();
        tick();
        check_reset_outputs("reset");
        rst = 1'b1;

        // Single requester: words 01,02,04,08.
        req = 4'b0100;
        expect_burst(req);
        check_burst(-1, 8'h00, -1);
        req = '0;

        // Same requester again: the sequence continues 11,23,...
        req = 4'b0100;
        expect_burst(req);
        check_burst(-1, 8'h00, -1);
        req = '0;

        // Reset to clear ptr, then all requesting: grant order 0,1,2,3,0.
        rst = 1'b0;
        tick();
        rst    = 1'b1;
        m_lfsr = SEED;
        m_ptr  = 3'd0;
        req    = 4'b1111;
        repeat (5) begin
            expect_burst(req);
            check_burst(-1, 8'h00, -1);
        end
        req = '0;

        // Seed 0x80 on the second beat: the burst is unaffected, SEED follows, and the next burst starts at 80.
        req = 4'b0010;
        expect_burst(req);
        check_burst(1, 8'h80, -1);
        req = '0;
        tick();
        chk("seed_busy",  32'(busy),      32'd1);
        chk("seed_gnt",   32'(gnt),       32'd0);
        chk("seed_valid", 32'(rnd_valid), 32'd0);
        tick();
        m_lfsr = 8'h80;
        chk("seeded_data", 32'(rnd_data), 32'h80);
        chk("seeded_busy", 32'(busy),     32'd0);
        req = 4'b0010;
        expect_burst(req);
        check_burst(-1, 8'h00, -1);
        req = '0;

        // Zero seed in IDLE: the lockup guard restores SEED.
        seed_load = 1'b1;
        seed_data = 8'h00;
        tick();
        seed_load = 1'b0;
        chk("zseed_busy", 32'(busy), 32'd1);
        tick();
        m_lfsr = SEED;
        chk("zseed_data", 32'(rnd_data), 32'(SEED));
        req = 4'b0001;
        expect_burst(req);
        check_burst(-1, 8'h00, -1);
        req = '0;

        // Reset on the third beat, then the next grant starts at requester 0.
        req = 4'b1000;
        expect_burst(req);
        check_burst(-1, 8'h00, 2);
        req = 4'b1111;
        expect_burst(req);
        check_burst(-1, 8'h00, -1);
        req = '0;

`ifdef LFSR_SCHED_STALL_EN
        // Ready low for three cycles mid-burst: the word holds, and all four words still arrive.
        stall_beat = 1;
        req = 4'b0100;
        expect_burst(req);
        check_burst(-1, 8'h00, -1);
        req = '0;
        stall_beat = -1;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
